// File: rtl/npu_host_driver.sv
// npu_host_driver
//   Host-side driver for one NPU invocation per start command. It streams
//   config words into the NPU config FIFO, then streams input words into the
//   NPU input FIFO while it drains result words from the NPU output FIFO into
//   a small skid buffer toward the host.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for host_start; counts are latched when it is accepted
//   CONFIG  | forwarding config words until cfg_rem reaches 0
//   STREAM  | input and output sides run concurrently until both finish
//   DONE    | one-cycle completion pulse, then back to IDLE
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   host_start / *_count      start pulse and per-invocation word counts
//   host_busy, host_done      status (busy outside IDLE, done one pulse)
//   host_cfg_*                config stream from host (valid/ready)
//   host_in_*                 input stream from host (valid/ready)
//   host_out_*                result stream toward host (valid/ready)
//   npu_config_*              NPU config FIFO write port
//   npu_input_*               NPU input FIFO write port
//   npu_output_*              NPU output FIFO read port (1-cycle read latency)
module npu_host_driver #(
  parameter int CNT_W      = 8,
  parameter int OBUF_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,

  input  logic             host_start,
  input  logic [CNT_W-1:0] host_cfg_count,
  input  logic [CNT_W-1:0] host_in_count,
  input  logic [CNT_W-1:0] host_out_count,
  output logic             host_busy,
  output logic             host_done,

  input  logic [25:0]      host_cfg_data,
  input  logic             host_cfg_valid,
  output logic             host_cfg_ready,

  input  logic [31:0]      host_in_data,
  input  logic             host_in_valid,
  output logic             host_in_ready,

  output logic [31:0]      host_out_data,
  output logic             host_out_valid,
  input  logic             host_out_ready,

  output logic [25:0]      npu_config_data,
  output logic             npu_config_fifo_write_enable,
  input  logic             npu_config_fifo_full,

  output logic [31:0]      npu_input_data,
  output logic             npu_input_fifo_write_enable,
  input  logic             npu_input_fifo_full,

  output logic             npu_output_fifo_read_enable,
  input  logic [31:0]      npu_output_data,
  input  logic             npu_output_fifo_empty
);

  localparam int PTR_W = (OBUF_DEPTH > 1) ? $clog2(OBUF_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W:0] DEPTH_L = (OCC_W + 1)'(OBUF_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONFIG = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cfg_rem_q, cfg_rem_d;
  logic [CNT_W-1:0]   in_rem_q, in_rem_d;
  logic [CNT_W-1:0]   req_rem_q, req_rem_d;
  logic [CNT_W-1:0]   del_rem_q, del_rem_d;
  logic               inflight_q, inflight_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               busy_q, done_q;
  logic [31:0]        buf_q [OBUF_DEPTH];

  logic               cfg_acc, in_acc, push, pop, rd_en;
  logic [OCC_W:0]     level, limit;

  // Stream handshakes are combinational so a full flag drops ready in the
  // same cycle it rises.
  assign host_cfg_ready = (state_q == S_CONFIG) && !npu_config_fifo_full &&
                          (cfg_rem_q != '0);
  assign host_in_ready  = (state_q == S_STREAM) && !npu_input_fifo_full &&
                          (in_rem_q != '0);
  assign cfg_acc = host_cfg_valid && host_cfg_ready;
  assign in_acc  = host_in_valid && host_in_ready;

  assign npu_config_data              = host_cfg_data;
  assign npu_config_fifo_write_enable = cfg_acc;
  assign npu_input_data               = host_in_data;
  assign npu_input_fifo_write_enable  = in_acc;

  assign host_out_valid = (occ_q != '0);
  assign host_out_data  = buf_q[rd_ptr_q];
  assign pop  = host_out_valid && host_out_ready;
  assign push = inflight_q;

  // A slot is reserved for the word already in flight; a same-cycle pop frees
  // one, which keeps a depth-2 buffer at one word per cycle.
  assign level = {1'b0, occ_q} + {{OCC_W{1'b0}}, inflight_q};
  assign limit = DEPTH_L + {{OCC_W{1'b0}}, pop};
  assign rd_en = (state_q == S_STREAM) && !npu_output_fifo_empty &&
                 (req_rem_q != '0) && (level < limit);
  assign npu_output_fifo_read_enable = rd_en;

  assign host_busy = busy_q;
  assign host_done = done_q;

  always_comb begin
    state_d    = state_q;
    cfg_rem_d  = cfg_rem_q;
    in_rem_d   = in_rem_q;
    req_rem_d  = req_rem_q;
    del_rem_d  = del_rem_q;
    inflight_d = rd_en;
    occ_d      = occ_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;

    if (cfg_acc) cfg_rem_d = cfg_rem_q - 1'b1;
    if (in_acc)  in_rem_d  = in_rem_q - 1'b1;
    if (rd_en)   req_rem_d = req_rem_q - 1'b1;
    if (pop && (del_rem_q != '0)) del_rem_d = del_rem_q - 1'b1;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (host_start) begin
          cfg_rem_d = host_cfg_count;
          in_rem_d  = host_in_count;
          req_rem_d = host_out_count;
          del_rem_d = host_out_count;
          state_d   = (host_cfg_count != '0) ? S_CONFIG : S_STREAM;
        end
      end
      S_CONFIG: begin
        if ((cfg_acc && (cfg_rem_q == CNT_W'(1))) || (cfg_rem_q == '0))
          state_d = S_STREAM;
      end
      S_STREAM: begin
        if ((in_rem_q == '0) && (del_rem_q == '0))
          state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cfg_rem_q  <= '0;
      in_rem_q   <= '0;
      req_rem_q  <= '0;
      del_rem_q  <= '0;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_rem_q  <= cfg_rem_d;
      in_rem_q   <= in_rem_d;
      req_rem_q  <= req_rem_d;
      del_rem_q  <= del_rem_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= (state_d == S_DONE);
    end
  end

  // Data storage needs no reset: occupancy gates host_out_valid.
  always_ff @(posedge CLK) begin
    if (push && !RST) buf_q[wr_ptr_q] <= npu_output_data;
  end

endmodule

// File: tb/tb_npu_host_driver.sv
module tb_npu_host_driver;

  localparam int CNT_W = 8;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             host_start = 1'b0;
  logic [CNT_W-1:0] host_cfg_count = '0;
  logic [CNT_W-1:0] host_in_count = '0;
  logic [CNT_W-1:0] host_out_count = '0;
  logic             host_busy, host_done;
  logic [25:0]      host_cfg_data;
  logic             host_cfg_valid = 1'b0;
  logic             host_cfg_ready;
  logic [31:0]      host_in_data;
  logic             host_in_valid = 1'b0;
  logic             host_in_ready;
  logic [31:0]      host_out_data;
  logic             host_out_valid;
  logic             host_out_ready = 1'b0;
  logic [25:0]      npu_config_data;
  logic             npu_config_fifo_write_enable;
  logic             npu_config_fifo_full = 1'b0;
  logic [31:0]      npu_input_data;
  logic             npu_input_fifo_write_enable;
  logic             npu_input_fifo_full = 1'b0;
  logic             npu_output_fifo_read_enable;
  logic [31:0]      npu_output_data = '0;
  logic             npu_output_fifo_empty;

  always #5 CLK = ~CLK;

  npu_host_driver #(.CNT_W(CNT_W), .OBUF_DEPTH(2)) dut (
    .CLK(CLK), .RST(RST),
    .host_start(host_start),
    .host_cfg_count(host_cfg_count), .host_in_count(host_in_count),
    .host_out_count(host_out_count),
    .host_busy(host_busy), .host_done(host_done),
    .host_cfg_data(host_cfg_data), .host_cfg_valid(host_cfg_valid),
    .host_cfg_ready(host_cfg_ready),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid),
    .host_in_ready(host_in_ready),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid),
    .host_out_ready(host_out_ready),
    .npu_config_data(npu_config_data),
    .npu_config_fifo_write_enable(npu_config_fifo_write_enable),
    .npu_config_fifo_full(npu_config_fifo_full),
    .npu_input_data(npu_input_data),
    .npu_input_fifo_write_enable(npu_input_fifo_write_enable),
    .npu_input_fifo_full(npu_input_fifo_full),
    .npu_output_fifo_read_enable(npu_output_fifo_read_enable),
    .npu_output_data(npu_output_data),
    .npu_output_fifo_empty(npu_output_fifo_empty)
  );

  // NPU output FIFO model and transfer logs
  logic [31:0] fifo_mem [64];
  int          fifo_wr = 0;
  int          fifo_rd = 0;
  logic        tb_clr = 1'b0;
  int          cfg_target = 0;
  int          cfg_wr_n = 0, in_wr_n = 0, rd_n = 0, pop_n = 0;
  int          viol_n = 0, order_n = 0;
  logic [25:0] cfg_log [16];
  logic [31:0] in_log  [16];
  logic [31:0] pop_log [16];

  assign npu_output_fifo_empty = (fifo_rd == fifo_wr);
  assign host_cfg_data = 26'h100 + 26'(cfg_wr_n);
  assign host_in_data  = 32'h2000_0000 + 32'(in_wr_n);

  always @(posedge CLK) begin
    if (tb_clr) begin
      fifo_rd  <= fifo_wr;
      cfg_wr_n <= 0; in_wr_n <= 0; rd_n <= 0; pop_n <= 0;
      viol_n   <= 0; order_n <= 0;
    end else begin
      if (npu_config_fifo_write_enable) begin
        cfg_log[cfg_wr_n[3:0]] <= npu_config_data;
        cfg_wr_n <= cfg_wr_n + 1;
      end
      if (npu_input_fifo_write_enable) begin
        in_log[in_wr_n[3:0]] <= npu_input_data;
        in_wr_n <= in_wr_n + 1;
      end
      if (npu_output_fifo_read_enable) begin
        npu_output_data <= fifo_mem[fifo_rd[5:0]];
        fifo_rd <= fifo_rd + 1;
        rd_n <= rd_n + 1;
      end
      if (host_out_valid && host_out_ready) begin
        pop_log[pop_n[3:0]] <= host_out_data;
        pop_n <= pop_n + 1;
      end
      if ((npu_config_fifo_write_enable && npu_config_fifo_full) ||
          (npu_input_fifo_write_enable && npu_input_fifo_full) ||
          (npu_output_fifo_read_enable && npu_output_fifo_empty))
        viol_n <= viol_n + 1;
      if ((npu_input_fifo_write_enable || npu_output_fifo_read_enable) &&
          (cfg_wr_n < cfg_target))
        order_n <= order_n + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    tb_clr = 1'b1;
    @(negedge CLK);
    tb_clr = 1'b0;
  endtask

  task automatic load_npu(input logic [31:0] w);
    fifo_mem[fifo_wr[5:0]] = w;
    fifo_wr++;
  endtask

  task automatic start_run(input int c, input int i, input int o);
    host_cfg_count = CNT_W'(c);
    host_in_count  = CNT_W'(i);
    host_out_count = CNT_W'(o);
    host_start = 1'b1;
    @(negedge CLK);
    host_start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int k);
    k = 0;
    while (!host_done && k < max) begin
      @(negedge CLK);
      k++;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(host_busy), 0);
    check({tag, "_done"}, 32'(host_done), 0);
    check({tag, "_cfg_rdy"}, 32'(host_cfg_ready), 0);
    check({tag, "_in_rdy"}, 32'(host_in_ready), 0);
    check({tag, "_out_vld"}, 32'(host_out_valid), 0);
    check({tag, "_enables"}, {29'd0, npu_config_fifo_write_enable,
          npu_input_fifo_write_enable, npu_output_fifo_read_enable}, 0);
  endtask

  int k;

  initial begin
    // reset state
    repeat (3) @(negedge CLK);
    host_cfg_valid = 1'b1;
    host_in_valid  = 1'b1;
    #1;
    check_idle_outputs("rst");
    RST = 1'b0;
    host_cfg_valid = 1'b0;
    host_in_valid  = 1'b0;
    clear_model();

    // basic run: cfg=3 in=4 out=2
    load_npu(32'hA0); load_npu(32'hA1);
    cfg_target = 3;
    host_cfg_valid = 1'b1; host_in_valid = 1'b1; host_out_ready = 1'b1;
    start_run(3, 4, 2);
    check("t1_busy", 32'(host_busy), 1);
    wait_done(40, k);
    check("t1_done_seen", 32'(host_done), 1);
    check("t1_done_cycle", 32'(k), 8);
    check("t1_cfg_writes", 32'(cfg_wr_n), 3);
    check("t1_in_writes", 32'(in_wr_n), 4);
    check("t1_reads", 32'(rd_n), 2);
    check("t1_pops", 32'(pop_n), 2);
    check("t1_pop0", pop_log[0], 32'hA0);
    check("t1_pop1", pop_log[1], 32'hA1);
    check("t1_cfg0", 32'(cfg_log[0]), 32'h100);
    check("t1_cfg2", 32'(cfg_log[2]), 32'h102);
    check("t1_in0", in_log[0], 32'h2000_0000);
    check("t1_in3", in_log[3], 32'h2000_0003);
    check("t1_order", 32'(order_n), 0);
    @(negedge CLK);
    check("t1_done_pulse", 32'(host_done), 0);
    check("t1_idle", 32'(host_busy), 0);
    host_cfg_valid = 1'b0; host_in_valid = 1'b0; host_out_ready = 1'b0;
    clear_model();

    // config FIFO full for 5 cycles mid-CONFIG
    cfg_target = 3;
    host_cfg_valid = 1'b1;
    start_run(3, 0, 0);
    @(negedge CLK);
    npu_config_fifo_full = 1'b1;
    #1;
    check("t2_rdy_full", 32'(host_cfg_ready), 0);
    check("t2_we_full", 32'(npu_config_fifo_write_enable), 0);
    check("t2_held_word", 32'(npu_config_data), 32'h101);
    repeat (4) @(negedge CLK);
    check("t2_rdy_full_end", 32'(host_cfg_ready), 0);
    check("t2_writes_full", 32'(cfg_wr_n), 1);
    @(negedge CLK);
    npu_config_fifo_full = 1'b0;
    wait_done(20, k);
    check("t2_done_seen", 32'(host_done), 1);
    check("t2_done_cycle", 32'(k), 3);
    check("t2_cfg_writes", 32'(cfg_wr_n), 3);
    check("t2_cfg1", 32'(cfg_log[1]), 32'h101);
    check("t2_cfg2", 32'(cfg_log[2]), 32'h102);
    @(negedge CLK);
    host_cfg_valid = 1'b0;
    clear_model();

    // back-pressure: out=5, host not ready, one surplus NPU word
    cfg_target = 0;
    for (int i = 0; i < 6; i++) load_npu(32'hB0 + 32'(i));
    start_run(0, 0, 5);
    repeat (5) @(negedge CLK);
    check("t3_reads_held", 32'(rd_n), 2);
    check("t3_rd_en_held", 32'(npu_output_fifo_read_enable), 0);
    check("t3_out_vld", 32'(host_out_valid), 1);
    check("t3_out_head", host_out_data, 32'hB0);
    host_out_ready = 1'b1;
    wait_done(30, k);
    check("t3_done_seen", 32'(host_done), 1);
    check("t3_done_cycle", 32'(k), 6);
    check("t3_reads", 32'(rd_n), 5);
    check("t3_pops", 32'(pop_n), 5);
    for (int i = 0; i < 5; i++)
      check($sformatf("t3_pop%0d", i), pop_log[i], 32'hB0 + 32'(i));
    @(negedge CLK);
    host_out_ready = 1'b0;
    clear_model();

    // zero-count invocation with host streams valid and NPU data available
    load_npu(32'hEE);
    host_cfg_valid = 1'b1; host_in_valid = 1'b1; host_out_ready = 1'b1;
    start_run(0, 0, 0);
    check("t4_busy1", 32'(host_busy), 1);
    check("t4_done1", 32'(host_done), 0);
    @(negedge CLK);
    check("t4_busy2", 32'(host_busy), 1);
    check("t4_done2", 32'(host_done), 1);
    @(negedge CLK);
    check("t4_busy3", 32'(host_busy), 0);
    check("t4_done3", 32'(host_done), 0);
    check("t4_enables", 32'(cfg_wr_n + in_wr_n + rd_n), 0);
    host_cfg_valid = 1'b0; host_in_valid = 1'b0; host_out_ready = 1'b0;
    clear_model();

    // reset mid-STREAM with one word buffered and one in flight
    cfg_target = 0;
    load_npu(32'hC0); load_npu(32'hC1); load_npu(32'hC2);
    start_run(0, 2, 3);
    repeat (2) @(negedge CLK);
    check("t5_buffered", 32'(host_out_valid), 1);
    check("t5_head", host_out_data, 32'hC0);
    check("t5_reads", 32'(rd_n), 2);
    RST = 1'b1;
    @(negedge CLK);
    host_in_valid = 1'b1;
    host_cfg_valid = 1'b1;
    #1;
    check_idle_outputs("t5_rst");
    RST = 1'b0;
    host_in_valid = 1'b0;
    host_cfg_valid = 1'b0;
    clear_model();
    load_npu(32'hD0);
    cfg_target = 1;
    host_cfg_valid = 1'b1; host_in_valid = 1'b1; host_out_ready = 1'b1;
    start_run(1, 1, 1);
    wait_done(30, k);
    check("t5_done_seen", 32'(host_done), 1);
    check("t5_cfg_writes", 32'(cfg_wr_n), 1);
    check("t5_in_writes", 32'(in_wr_n), 1);
    check("t5_pops", 32'(pop_n), 1);
    check("t5_pop0", pop_log[0], 32'hD0);
    check("t5_order", 32'(order_n), 0);
    @(negedge CLK);
    host_cfg_valid = 1'b0; host_in_valid = 1'b0; host_out_ready = 1'b0;
    clear_model();

    // start while busy is ignored
    cfg_target = 2;
    load_npu(32'hE0); load_npu(32'hE1); load_npu(32'hE2);
    start_run(2, 1, 1);
    host_cfg_count = 8'd7; host_in_count = 8'd7; host_out_count = 8'd7;
    host_start = 1'b1;
    @(negedge CLK);
    host_start = 1'b0;
    host_cfg_count = '0; host_in_count = '0; host_out_count = '0;
    host_cfg_valid = 1'b1; host_in_valid = 1'b1; host_out_ready = 1'b1;
    wait_done(40, k);
    check("t6_done_seen", 32'(host_done), 1);
    check("t6_cfg_writes", 32'(cfg_wr_n), 2);
    check("t6_in_writes", 32'(in_wr_n), 1);
    check("t6_reads", 32'(rd_n), 1);
    check("t6_pop0", pop_log[0], 32'hE0);
    check("t6_flag_viol", 32'(viol_n), 0);
    @(negedge CLK);
    check("t6_idle", 32'(host_busy), 0);
    host_cfg_valid = 1'b0; host_in_valid = 1'b0; host_out_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
